wb_ram_slave: RTL and testbench

Wishbone B3 responder backed by on-chip synchronous RAM, the target side of the same bus our `wb0`/`wb1`/`wb4` bench masters drive into `wb_sdram_ctrl_top`. It answers classic and registered-feedback burst cycles (constant-address and incrementing linear/wrap-4/8/16) with single-cycle beats after a one-cycle initial wait state. It is used as a scratch RAM port in the SoC and as a golden responder when qualifying the masters independently of SDRAM.

---
 rtl/wb_ram_slave.sv | 124 ++++++++++++
 tb/tb_wb_ram_slave.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_slave.sv
// wb_ram_slave: Wishbone B3 responder backed by a synchronous 32-bit RAM.
// Handles classic and registered-feedback bursts: constant-address and
// incrementing (linear, wrap-4/8/16). Every transaction starts with one
// wait state and then delivers single-cycle beats.
module wb_ram_slave #(
    parameter int ADR_WIDTH = 10   // must be >= 4 so that wrap-16 fits
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst,
    input  logic [ADR_WIDTH-1:0] wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [2:0]           wbs_cti_i,
    input  logic [1:0]           wbs_bte_i,
    input  logic                 wbs_we_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    output logic [31:0]          wbs_dat_o,
    output logic                 wbs_ack_o,
    output logic                 wbs_err_o
);

    localparam int DEPTH = 1 << ADR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_ERR    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ADR_WIDTH-1:0] cnt_q, cnt_d;     // current beat address
    logic [31:0]          rdata_q;          // registered RAM output
    logic                 ack;
    logic                 wr_en;
    logic                 req;
    logic                 cti_legal;

    logic [31:0] mem [DEPTH];

    // Next beat address: only the bits selected by the wrap mask advance,
    // the rest stay fixed. Linear uses an all-ones mask, so it wraps at the
    // top of the RAM.
    function automatic logic [ADR_WIDTH-1:0] inc(input logic [ADR_WIDTH-1:0] a,
                                                 input logic [1:0]           bte);
        logic [ADR_WIDTH-1:0] m;
        m = '1;
        case (bte)
            2'b01:   begin m = '0; m[1:0] = '1; end
            2'b10:   begin m = '0; m[2:0] = '1; end
            2'b11:   begin m = '0; m[3:0] = '1; end
            default: m = '1;
        endcase
        return (a & ~m) | ((a + ADR_WIDTH'(1)) & m);
    endfunction

    assign req       = wbs_cyc_i & wbs_stb_i;
    assign cti_legal = (wbs_cti_i == 3'b000) || (wbs_cti_i == 3'b001) ||
                       (wbs_cti_i == 3'b010) || (wbs_cti_i == 3'b111);

    // Next-state, beat address and beat acknowledge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack     = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (cti_legal) begin
                        state_d = S_ACTIVE;
                        cnt_d   = wbs_adr_i;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_ACTIVE: begin
                if (!wbs_cyc_i) begin
                    state_d = S_IDLE;              // abort, nothing written
                end else if (wbs_stb_i) begin
                    ack   = 1'b1;
                    wr_en = wbs_we_i;
                    case (wbs_cti_i)
                        3'b001:  cnt_d   = cnt_q;  // constant-address burst
                        3'b010:  cnt_d   = inc(cnt_q, wbs_bte_i);
                        default: state_d = S_IDLE; // classic, end, or reserved
                    endcase
                end
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, beat address and read register. The RAM is read at cnt_d, so
    // the registered output always tracks mem[cnt_q] in ACTIVE.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= mem[cnt_d];
        end
    end

    // Byte-lane write port; contents are never reset, and a reset edge
    // suppresses the write of an in-flight beat.
    always_ff @(posedge wb_clk) begin
        if (wr_en && !wb_rst) begin
            for (int b = 0; b < 4; b++) begin
                if (wbs_sel_i[b]) mem[cnt_q][8*b +: 8] <= wbs_dat_i[8*b +: 8];
            end
        end
    end

    assign wbs_ack_o = ack;
    assign wbs_err_o = (state_q == S_ERR);
    assign wbs_dat_o = rdata_q;

endmodule

// File: tb/tb_wb_ram_slave.sv
// tb_wb_ram_slave: directed bench for wb_ram_slave. A 10-bit instance and a
// 4-bit instance share one bus; the 4-bit one sees the low address nibble
// and is checked in the top-of-RAM linear wrap step.
module tb_wb_ram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        we, cyc, stb;
    logic [31:0] dat_o, dat4;
    logic        ack, err, ack4, err4;

    int vectors     = 0;
    int miscompares = 0;
    int cycles      = 0;
    bit chk4        = 1'b0;

    logic [31:0] m10 [1024];
    logic [31:0] m4  [16];
    logic [31:0] q10 [$];
    logic [31:0] q4  [$];

    always #5 clk = ~clk;
    always @(posedge clk) cycles <= cycles + 1;

    wb_ram_slave #(.ADR_WIDTH(10)) dut (
        .wb_clk(clk), .wb_rst(rst), .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_sel_i(sel), .wbs_cti_i(cti), .wbs_bte_i(bte), .wbs_we_i(we),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_dat_o(dat_o),
        .wbs_ack_o(ack), .wbs_err_o(err)
    );

    wb_ram_slave #(.ADR_WIDTH(4)) dut4 (
        .wb_clk(clk), .wb_rst(rst), .wbs_adr_i(adr[3:0]), .wbs_dat_i(dat),
        .wbs_sel_i(sel), .wbs_cti_i(cti), .wbs_bte_i(bte), .wbs_we_i(we),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_dat_o(dat4),
        .wbs_ack_o(ack4), .wbs_err_o(err4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mwrite(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) begin
                m10[a][8*b +: 8]      = d[8*b +: 8];
                m4[a[3:0]][8*b +: 8]  = d[8*b +: 8];
            end
        end
    endtask

    task automatic expect_rd(input logic [9:0] a);
        q10.push_back(m10[a]);
        q4.push_back(m4[a[3:0]]);
    endtask

    task automatic drive(input logic w, input logic [9:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] c, input logic [1:0] b);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s; cti = c; bte = b;
    endtask

    task automatic release_bus();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    endtask

    // Wait (bounded) for one ack, check its latency and, for reads, the data
    // popped from the scoreboard. Returns just after the completing edge.
    task automatic wait_ack(input string tag, input int exp_wait);
        int n;
        logic [31:0] e10, e4;
        n = 0;
        @(negedge clk);
        while (ack !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " ack"}, {31'd0, ack}, 32'd1);
        chk({tag, " wait"}, n, exp_wait);
        chk({tag, " err"}, {31'd0, err}, 32'd0);
        if (!we) begin
            if (q10.size() == 0) begin
                chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
            end else begin
                e10 = q10.pop_front();
                e4  = q4.pop_front();
                chk({tag, " rdata"}, dat_o, e10);
                if (chk4) begin
                    chk({tag, " ack4"}, {31'd0, ack4}, 32'd1);
                    chk({tag, " rdata4"}, dat4, e4);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic classic_wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                              input string tag);
        drive(1'b1, a, d, s, 3'b000, 2'b00);
        mwrite(a, d, s);
        wait_ack(tag, 1);
        release_bus();
    endtask

    task automatic read_exp(input logic [9:0] a, input logic [31:0] e, input string tag);
        drive(1'b0, a, 32'd0, 4'hF, 3'b000, 2'b00);
        q10.push_back(e);
        q4.push_back(m4[a[3:0]]);
        wait_ack(tag, 1);
        release_bus();
    endtask

    initial begin
        int start;
        rst = 1'b1;
        adr = '0; dat = '0; sel = '0; cti = '0; bte = '0;
        we = 1'b0; cyc = 1'b0; stb = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset ack",  {31'd0, ack}, 32'd0);
        chk("reset err",  {31'd0, err}, 32'd0);
        chk("reset dat",  dat_o, 32'd0);
        chk("reset ack4/err4", {30'd0, ack4, err4}, 32'd0);
        @(posedge clk); #1;

        // Classic write then read.
        classic_wr(10'h010, 32'hDEADBEEF, 4'hF, "classic wr");
        read_exp(10'h010, 32'hDEADBEEF, "classic rd");

        // Byte lanes.
        classic_wr(10'd5, 32'h11223344, 4'hF, "lanes wr full");
        classic_wr(10'd5, 32'hAABBCCDD, 4'b0101, "lanes wr 0101");
        read_exp(10'd5, 32'h11BB33DD, "lanes rd");

        // Wrap-4 read burst from 6 over mem[k]=k.
        for (int k = 0; k < 8; k++) classic_wr(10'(k), 32'(k), 4'hF, "preload");
        drive(1'b0, 10'd6, 32'd0, 4'hF, 3'b010, 2'b01);
        start = cycles;
        q10.push_back(32'd6); q4.push_back(32'd6);
        q10.push_back(32'd7); q4.push_back(32'd7);
        q10.push_back(32'd4); q4.push_back(32'd4);
        q10.push_back(32'd5); q4.push_back(32'd5);
        wait_ack("wrap4 b0", 1);
        wait_ack("wrap4 b1", 0);
        wait_ack("wrap4 b2", 0);
        cti = 3'b111;
        wait_ack("wrap4 b3", 0);
        chk("wrap4 cycles", cycles - start, 32'd5);
        release_bus();

        // Linear burst across the top of RAM with a two-cycle stb gap.
        classic_wr(10'd1022, 32'hA0000000 + 32'd1022, 4'hF, "top preload");
        classic_wr(10'd1023, 32'hA0000000 + 32'd1023, 4'hF, "top preload");
        classic_wr(10'd0,    32'hA0000000,            4'hF, "top preload");
        classic_wr(10'd1,    32'hA0000001,            4'hF, "top preload");
        chk4 = 1'b1;
        drive(1'b0, 10'd1022, 32'd0, 4'hF, 3'b010, 2'b00);
        expect_rd(10'd1022); expect_rd(10'd1023); expect_rd(10'd0); expect_rd(10'd1);
        wait_ack("lin b0", 1);
        wait_ack("lin b1", 0);
        stb = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("lin gap ack", {30'd0, ack, ack4}, 32'd0);
            @(posedge clk); #1;
        end
        stb = 1'b1;
        wait_ack("lin b2", 0);
        cti = 3'b111;
        wait_ack("lin b3", 0);
        release_bus();
        chk4 = 1'b0;

        // Reserved cti: one-cycle error, no ack, no write.
        drive(1'b1, 10'h010, 32'h0BAD0BAD, 4'hF, 3'b011, 2'b00);
        @(negedge clk);
        chk("err pre", {30'd0, ack, err}, 32'd0);
        @(negedge clk);
        chk("err pulse", {30'd0, ack, err}, 32'd1);
        release_bus();
        @(negedge clk);
        chk("err one cycle", {30'd0, ack, err}, 32'd0);
        @(posedge clk); #1;
        read_exp(10'h010, 32'hDEADBEEF, "err mem");

        // Abort a write burst after beat 1.
        classic_wr(10'h021, 32'h55555555, 4'hF, "abort preload");
        drive(1'b1, 10'h020, 32'h11111111, 4'hF, 3'b010, 2'b00);
        mwrite(10'h020, 32'h11111111, 4'hF);
        wait_ack("abort b1", 1);
        dat = 32'h22222222;
        release_bus();
        @(posedge clk); #1;
        read_exp(10'h020, 32'h11111111, "abort rd b1");
        read_exp(10'h021, 32'h55555555, "abort rd b2");

        // Reset during beat 2 of a write burst.
        classic_wr(10'h030, 32'hC0C0C0C0, 4'hF, "rst preload");
        classic_wr(10'h031, 32'hC1C1C1C1, 4'hF, "rst preload");
        drive(1'b1, 10'h030, 32'h12345678, 4'hF, 3'b010, 2'b00);
        mwrite(10'h030, 32'h12345678, 4'hF);
        wait_ack("rst b1", 1);
        dat = 32'h9ABCDEF0;
        @(negedge clk);
        chk("rst b2 ack", {31'd0, ack}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        release_bus();
        @(negedge clk);
        chk("rst after ack/err", {30'd0, ack, err}, 32'd0);
        chk("rst after dat", dat_o, 32'd0);
        @(posedge clk); #1;
        read_exp(10'h030, 32'h12345678, "rst rd b1");
        read_exp(10'h031, 32'hC1C1C1C1, "rst rd b2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
